// File: rtl/aes_round_key_store.sv
// aes_round_key_store
//   Sits directly behind the AES-128 key expander. On an accepted start it
//   fires a one-cycle load into the expander, captures the eleven round keys
//   (RK0..RK10) that the expander presents on consecutive cycles, then serves
//   them through a registered random-access read port with one cycle latency.
//
// Ports
//   clk                 clock, all state updates on posedge
//   rst_n               asynchronous active-low reset
//   start, key          new-expansion request and cipher key (sampled when not busy)
//   exp_start, exp_key  load pulse and key to the expander (registered)
//   exp_w0..exp_w3      expander word outputs, exp_w0 is the most significant word
//   busy, ready         capture in progress / full schedule available
//   rd_en, rd_idx       read request and round-key index
//   rd_valid, rd_data   registered read response
//
// Build option
//   AES_RKS_DEC_ORDER_EN  defined: rd_idx k returns RK(10-k) (decryption order)
//                         undefined: rd_idx k returns RKk (encryption order)
//
// state | meaning
// IDLE  | no schedule held, waiting for start
// LOAD  | exp_start pulse to the expander
// CAPT  | writing slot cnt each cycle, 0..10
// DONE  | schedule complete, reads accepted, start re-keys

module aes_round_key_store (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         exp_start,
  output logic [127:0] exp_key,
  input  logic [31:0]  exp_w0,
  input  logic [31:0]  exp_w1,
  input  logic [31:0]  exp_w2,
  input  logic [31:0]  exp_w3,
  output logic         busy,
  output logic         ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic [127:0] rd_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int         NUM_RK  = 11;
  localparam logic [3:0] LAST_RK = 4'd10;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [127:0] slot_q [NUM_RK];
  logic [127:0] cap_word;
  logic         cap_en;
  logic [3:0]   rd_slot;
  logic         rd_in_range;
  logic [127:0] rd_word;
  logic         rd_accept;

  assign busy      = (state == ST_LOAD) || (state == ST_CAPT);
  assign ready     = (state == ST_DONE);
  assign cap_word  = {exp_w0, exp_w1, exp_w2, exp_w3};
  assign cap_en    = (state == ST_CAPT);
  assign rd_accept = rd_en && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      exp_start <= 1'b0;
      exp_key   <= '0;
    end else begin
      exp_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            exp_start <= 1'b1;
            exp_key   <= key;
            cnt       <= 4'd0;
          end
        end
        ST_LOAD: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          // cnt stops at 10: the 11th write leaves the state instead of wrapping
          if (cnt == LAST_RK) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RK; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (cap_en && (cnt == 4'(i))) begin
          slot_q[i] <= cap_word;
        end
      end
    end
  end

`ifdef AES_RKS_DEC_ORDER_EN
  assign rd_slot = LAST_RK - rd_idx;
`else
  assign rd_slot = rd_idx;
`endif

  // range test uses the raw index so out-of-range reads give zero in both orders
  assign rd_in_range = (rd_idx <= LAST_RK);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rd_slot == 4'(i)) begin
        rd_word = slot_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_in_range ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_store.sv
module tb_aes_round_key_store;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         exp_start;
  logic [127:0] exp_key;
  logic [31:0]  exp_w0, exp_w1, exp_w2, exp_w3;
  logic         busy;
  logic         ready;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_valid;
  logic [127:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_key_store dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .exp_start (exp_start),
    .exp_key   (exp_key),
    .exp_w0    (exp_w0),
    .exp_w1    (exp_w1),
    .exp_w2    (exp_w2),
    .exp_w3    (exp_w3),
    .busy      (busy),
    .ready     (ready),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 key schedule, straight from the algorithm ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] v;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  // ---------------- expander stand-in: RK0 the cycle after the load ----------------
  logic [1407:0] x_sched = '0;
  int            x_step  = 15;

  always @(posedge clk) begin
    if (exp_start) begin
      x_sched <= expand(exp_key);
      x_step  <= 0;
    end else if (x_step < 15) begin
      x_step <= x_step + 1;
    end
  end

  assign {exp_w0, exp_w1, exp_w2, exp_w3} =
    (x_step <= 10) ? x_sched[x_step*128 +: 128] : 128'h5a5a_a5a5_dead_beef_0f0f_f0f0_1234_5678;

  // ---------------- reference model state ----------------
  logic [1407:0] ref_sched = '0;
  logic          ref_ready = 1'b0;
  logic [127:0]  last_rd   = '0;

  function automatic logic [127:0] ref_read(input logic [3:0] idx);
    int s;
    if (idx > 10) return '0;
`ifdef AES_RKS_DEC_ORDER_EN
    s = 10 - int'(idx);
`else
    s = int'(idx);
`endif
    return ref_sched[s*128 +: 128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic en);
    logic exp_v;
    rd_en  = en;
    rd_idx = idx;
    tick();
    exp_v = en && ref_ready;
    check("rd_valid", {127'd0, rd_valid}, {127'd0, exp_v});
    if (exp_v) last_rd = ref_read(idx);
    check("rd_data", rd_data, last_rd);
  endtask

  task automatic run_start(input logic [127:0] k, input bit restart_mid, input bit read_during);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    ref_ready = 1'b0;
    ref_sched = expand(k);
    check("e0_exp_start", {127'd0, exp_start}, 128'd1);
    check("e0_exp_key", exp_key, k);
    check("e0_busy", {127'd0, busy}, 128'd1);
    check("e0_ready", {127'd0, ready}, 128'd0);
    for (int c = 1; c <= 12; c++) begin
      if (restart_mid && c == 5) begin
        start = 1'b1;
        key   = ~k;
      end
      if (read_during) begin
        rd_en  = 1'b1;
        rd_idx = 4'($urandom_range(0, 15));
      end
      tick();
      start = 1'b0;
      check("exp_start_pulse", {127'd0, exp_start}, 128'd0);
      check("busy_window", {127'd0, busy}, {127'd0, (c < 12)});
      check("ready_rise", {127'd0, ready}, {127'd0, (c == 12)});
      if (read_during) begin
        check("busy_rd_valid", {127'd0, rd_valid}, 128'd0);
        check("busy_rd_hold", rd_data, last_rd);
      end
    end
    rd_en = 1'b0;
    ref_ready = 1'b1;
    check("exp_key_held", exp_key, k);
  endtask

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk;
    rst_n  = 1'b0;
    start  = 1'b0;
    key    = '0;
    rd_en  = 1'b0;
    rd_idx = 4'd0;
    tick();
    tick();
    check("rst_exp_start", {127'd0, exp_start}, 128'd0);
    check("rst_exp_key", exp_key, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_ready", {127'd0, ready}, 128'd0);
    check("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("rst_rd_data", rd_data, 128'd0);
    rst_n = 1'b1;
    tick();
    do_read(4'd0, 1'b1);

    run_start(K1, 1'b0, 1'b0);
`ifdef AES_RKS_DEC_ORDER_EN
    do_read(4'd0, 1'b1);
    check("kat_idx0", rd_data, K1_R10);
    do_read(4'd10, 1'b1);
    check("kat_idx10", rd_data, K1);
`else
    do_read(4'd0, 1'b1);
    check("kat_idx0", rd_data, K1);
    do_read(4'd1, 1'b1);
    check("kat_idx1", rd_data, K1_RK1);
    do_read(4'd10, 1'b1);
    check("kat_idx10", rd_data, K1_R10);
`endif

    for (int i = 0; i <= 10; i++) do_read(4'(i), 1'b1);
    do_read(4'd11, 1'b1);
    do_read(4'd15, 1'b1);
    check("oor_zero", rd_data, 128'd0);
    do_read(4'd3, 1'b0);

    run_start(K1, 1'b1, 1'b0);
    for (int i = 0; i <= 10; i++) do_read(4'(i), 1'b1);

    run_start(K2, 1'b0, 1'b1);
`ifdef AES_RKS_DEC_ORDER_EN
    do_read(4'd0, 1'b1);
`else
    do_read(4'd10, 1'b1);
`endif
    check("kat2_rk10", rd_data, K2_R10);

    // asynchronous reset in the middle of a capture
    start = 1'b1;
    key   = K1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    ref_ready = 1'b0;
    last_rd   = '0;
    check("arst_exp_start", {127'd0, exp_start}, 128'd0);
    check("arst_exp_key", exp_key, 128'd0);
    check("arst_busy", {127'd0, busy}, 128'd0);
    check("arst_ready", {127'd0, ready}, 128'd0);
    check("arst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("arst_rd_data", rd_data, 128'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_read(4'(i * 3), 1'b1);

    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_start(rk, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      for (int n = 0; n < 40; n++) begin
        do_read(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_key_store.md
# aes_round_key_store

Capture-and-hold stage directly downstream of the AES-128 key expander. It issues the one-cycle load to the expander and captures the 11 round keys (RK0..RK10) the expander produces over consecutive cycles. It then serves them through a registered random-access read port. The stored schedule lets the cipher datapath, and in particular the decryption datapath that needs reverse-order keys, read any round key without re-running the expansion.

## Interface
Parameters:
- none (AES-128 only: 11 slots of 128 bits)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new expansion; sampled only while not busy
- key  input  128  cipher key, sampled together with start
- exp_start  output  1  to the expander's start_flag; registered one-cycle pulse
- exp_key  output  128  to the expander's key input; registered copy of key
- exp_w0..exp_w3  input  32 each  from the expander's word outputs; exp_w0 is bits [127:96]
- busy  output  1  expansion and capture in progress
- ready  output  1  all 11 slots hold the current key's schedule
- rd_en  input  1  read request
- rd_idx  input  4  round-key index 0..10
- rd_valid  output  1  rd_data is valid this cycle
- rd_data  output  128  registered round key

## Operation
States:
- IDLE: ready=0. start=1 -> LOAD.
- LOAD: exp_start=1 for exactly this cycle; exp_key holds the captured key -> CAPT.
- CAPT: each cycle writes {exp_w0,exp_w1,exp_w2,exp_w3} to slot cnt, then cnt++. cnt=10 written -> DONE.
- DONE: ready=1. start=1 -> LOAD (re-key).
- busy=1 in LOAD and CAPT.

Rules:
- cnt is 4 bits. It is cleared on entry to LOAD and counts 0..10 in CAPT. It never wraps; the 11th write exits the state.
- start while busy: ignored; no queueing.
- start in DONE: ready falls the next cycle. The old slots stay readable only until they are overwritten, but reads are refused because ready=0.
- Read: rd_en=1 while ready=1 -> rd_valid=1 and rd_data=slot[rd_idx] on the next cycle.
- rd_en while ready=0: rd_valid=0 next cycle, and rd_data holds its previous value.
- rd_idx > 10 with ready=1: rd_valid=1, rd_data=0.
- Reads and capture never overlap, because ready=0 throughout LOAD and CAPT.
- Reset values (any time, including mid-capture): state IDLE, cnt 0, all slots 0, exp_start 0, exp_key 0, busy 0, ready 0, rd_valid 0, rd_data 0.

## Timing
- Edge E0 samples start=1 in IDLE (or DONE). exp_start is high from E0 to E1.
- The expander loads RK0 at E1.
- Slot k is written at edge E(2+k): slot 0 at E2, slot 10 at E12.
- busy is high from E0 to E12. ready rises at E12.
- Start-to-ready latency: 12 cycles.
- Read latency: 1 cycle, fully pipelined. One read per cycle sustained.

## Configuration
- Macro AES_RKS_DEC_ORDER_EN.
  - Defined: the read address maps to slot 10-rd_idx for rd_idx 0..10. rd_idx=0 returns RK10, which is the decryption-order schedule. Out-of-range indices still return 0.
  - Undefined: the read address maps directly to slot rd_idx, which is encryption order.
- No port changes in either case.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle -> busy high 12 cycles, ready at E12. Reading idx 0 returns 2b7e151628aed2a6abf7158809cf4f3c. idx 1 returns a0fafe1788542cb123a339392a6c7605. idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6. With the macro defined, idx 0 and idx 10 return the swapped values.
- Back-to-back reads of idx 0..10 on consecutive cycles after ready -> 11 consecutive rd_valid cycles, each one cycle after its request. idx 11 and idx 15 -> rd_valid=1, rd_data=0.
- start pulsed again at E5 (during CAPT) -> ignored; the schedule and ready timing are identical to a single start.
- In DONE, start with key 000102030405060708090a0b0c0d0e0f -> ready low 12 cycles; reads during that window give rd_valid=0. Afterwards idx 10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- rst_n low at E7 -> all outputs 0 immediately (asynchronous). After release, reads give rd_valid=0 until a new start completes.
- exp_start is never high for more than one cycle per accepted start, and exp_key is stable while exp_start=1.
